aes_128_decrypt: RTL and testbench

AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

---
 rtl/aes_128_decrypt_pkg.sv | 115 +++++++++++
 rtl/aes_128_decrypt_inv_sbox.sv | 11 +
 rtl/aes_128_decrypt.sv | 113 +++++++++++
 tb/tb_aes_128_decrypt.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_decrypt_pkg.sv
// Shared definitions for the iterative AES-128 inverse cipher: FSM encoding,
// round constants, the S-box table and the GF(2^8) column arithmetic.
package aes_128_decrypt_pkg;

  localparam int ROUNDS  = 10;
  localparam int LATENCY = 21;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    INIT,
    ROUND,
    FINAL
  } fsm_e;

  // Entry i holds rcon(i+1); the round counter indexes this directly.
  localparam logic [ROUNDS-1:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Forward S-box, byte 0 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  // The inverse table is derived from the forward one at elaboration time.
  function automatic logic [2047:0] build_inv_sbox();
    logic [2047:0] t;
    logic [7:0]    s;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      s = SBOX_TBL[(255 - i) * 8 +: 8];
      t[(255 - int'(s)) * 8 +: 8] = i[7:0];
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX_TBL = build_inv_sbox();

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    return (int'(idx) < ROUNDS) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31 - 8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  // Row r rotates right by r columns; bytes are column-major.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_128_decrypt_inv_sbox.sv
// Combinational 8-bit AES inverse S-box lookup.
module inv_sbox
  import aes_128_decrypt_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = INV_SBOX_TBL[(255 - int'(a)) * 8 +: 8];

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher: expands the key forward to k10, then runs
// one decryption round per cycle while stepping the key schedule backwards.
module aes_128_decrypt
  import aes_128_decrypt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q;
  logic [127:0] state_q, key_q, out_q;
  logic         done_q;

  logic [127:0] shifted, inv_sub;
  logic [31:0]  w_a, w_b, w_c, w_d;
  logic [31:0]  sub_in, rot, sub_word, rcon_word;
  logic [127:0] key_fwd, key_rev;

  assign shifted = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    inv_sbox u_inv_sbox (
      .a (shifted[127 - 8*i -: 8]),
      .y (inv_sub[127 - 8*i -: 8])
    );
  end

  // One SubWord serves both directions: forward uses d, reverse uses d^c (= d').
  assign {w_a, w_b, w_c, w_d} = key_q;
  assign sub_in    = (fsm_q == EXPAND) ? w_d : (w_d ^ w_c);
  assign rot       = {sub_in[23:0], sub_in[31:24]};
  assign sub_word  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign rcon_word = {rcon_of(cnt_q), 24'h000000};

  always_comb begin
    logic [31:0] fa, fb, fc, fd;
    fa      = w_a ^ sub_word ^ rcon_word;
    fb      = w_b ^ fa;
    fc      = w_c ^ fb;
    fd      = w_d ^ fc;
    key_fwd = {fa, fb, fc, fd};
    key_rev = {w_a ^ sub_word ^ rcon_word, w_b ^ w_a, w_c ^ w_b, w_d ^ w_c};
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (start) fsm_d = EXPAND;
      EXPAND:  if (cnt_q == 4'(ROUNDS - 1)) fsm_d = INIT;
      INIT:    fsm_d = ROUND;
      ROUND:   if (cnt_q == 4'd0) fsm_d = FINAL;
      FINAL:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: every register, including the wide data registers, clears on reset so an aborted block leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      done_q <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            key_q   <= key;
            state_q <= in;
            cnt_q   <= '0;
          end
        end
        EXPAND: begin
          key_q <= key_fwd;
          if (cnt_q != 4'(ROUNDS - 1)) cnt_q <= cnt_q + 4'd1;
        end
        INIT: begin
          state_q <= state_q ^ key_q;
          key_q   <= key_rev;
          cnt_q   <= cnt_q - 4'd1;
        end
        ROUND: begin
          state_q <= inv_mix_columns(inv_sub ^ key_q);
          key_q   <= key_rev;
          cnt_q   <= cnt_q - 4'd1;
        end
        FINAL: begin
          out_q  <= inv_sub ^ key_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (fsm_q != IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Self-checking bench for aes_128_decrypt: FIPS-197 vectors, control corner
// cases and random blocks produced by an independent byte-level AES encryptor.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key, ct, out;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes_128_decrypt dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .in    (ct),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  // ---------------- reference model: plain byte-level AES-128 encryption
  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] t0, rc;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) w[i] = k[127 - 8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
      if (i % 16 == 0) begin
        t0     = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[t0];
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = s[row + 4*((c + row) % 4)];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (rnd < 10)
            s[row + 4*c] = gm(8'h02, t[4*c + row]) ^ gm(8'h03, t[4*c + (row+1)%4]) ^
                           t[4*c + (row+2)%4] ^ t[4*c + (row+3)%4];
          else
            s[row + 4*c] = t[row + 4*c];
      for (int i = 0; i < 16; i++) s[i] ^= w[16*rnd + i];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers
  // Returns at the falling edge right after the start edge E0; key/in are then scrambled.
  task automatic launch(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key = k; ct = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key = rnd128(); ct = rnd128();
  endtask

  // n counts rising edges since the reference edge; bounded so a dead DUT cannot hang the run.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < n0 + 45) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; key = '0; ct = '0;
    #2 rst = 1'b1;
    #20;
    total++; if (out !== 128'h0)  begin bad++; $display("FAIL reset_out: got %h want 0", out); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips_c1();
    int n;
    launch(C1_KEY, C1_CT);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL c1_busy_after_start: got %b want 1", busy); end
    wait_done(0, n);
    total++; if (n !== 21)      begin bad++; $display("FAIL c1_latency: got %0d want 21", n); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL c1_out: got %h want %h", out, C1_PT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL c1_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL c1_done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_fips_b();
    int n;
    launch(B_KEY, B_CT);
    wait_done(0, n);
    total++; if (n !== 21 || out !== B_PT)
      begin bad++; $display("FAIL b_vector: got %h lat %0d want %h lat 21", out, n, B_PT); end
  endtask

  task automatic test_zero_key();
    int n;
    launch(128'h0, Z_CT);
    wait_done(0, n);
    total++; if (n !== 21 || out !== 128'h0)
      begin bad++; $display("FAIL zero_vector: got %h lat %0d want 0 lat 21", out, n); end
  endtask

  task automatic test_ignored_start();
    int n;
    launch(C1_KEY, C1_CT);
    repeat (4) @(negedge clk);
    start = 1'b1; key = rnd128(); ct = rnd128();
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n);
    total++; if (n !== 21)      begin bad++; $display("FAIL ignored_start_latency: got %0d want 21", n); end
    total++; if (out !== C1_PT) begin bad++; $display("FAIL ignored_start_out: got %h want %h", out, C1_PT); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_start_queued: busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    launch(C1_KEY, C1_CT);
    wait_done(0, n1);
    total++; if (out !== C1_PT) begin bad++; $display("FAIL b2b_first_out: got %h want %h", out, C1_PT); end
    key = B_KEY; ct = B_CT; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key = rnd128(); ct = rnd128();
    wait_done(1, n2);
    total++; if (n2 !== 22)     begin bad++; $display("FAIL b2b_spacing: got %0d want 22", n2); end
    total++; if (out !== B_PT)  begin bad++; $display("FAIL b2b_second_out: got %h want %h", out, B_PT); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw_done;
    launch(C1_KEY, C1_CT);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (out !== 128'h0) begin bad++; $display("FAIL midreset_out: got %h want 0", out); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done: activity seen %b want 0", saw_done); end
    // Release reset with start already high: the next edge must be a start edge.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; key = C1_KEY; ct = C1_CT; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key = rnd128(); ct = rnd128();
    wait_done(0, n);
    total++; if (n !== 21 || out !== C1_PT)
      begin bad++; $display("FAIL midreset_rerun: got %h lat %0d want %h lat 21", out, n, C1_PT); end
  endtask

  task automatic test_random();
    logic [127:0] k, pt, c;
    int n;
    c = ref_encrypt(C1_KEY, C1_PT);
    total++; if (c !== C1_CT) begin bad++; $display("FAIL model_c1: got %h want %h", c, C1_CT); end
    for (int i = 0; i < 1000; i++) begin
      k  = rnd128();
      pt = rnd128();
      c  = ref_encrypt(k, pt);
      launch(k, c);
      wait_done(0, n);
      total++;
      if (n !== 21 || out !== pt) begin
        bad++;
        $display("FAIL random_%0d: key %h got %h lat %0d want %h lat 21", i, k, out, n, pt);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_zero_key();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
